// File: rtl/alu_control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_sequencer_pkg
// Purpose  : Shared CPU definitions for the hardwired control sequencer:
//            the ALU opcode values, the sequencer state encoding, the IR field
//            bit positions and the legal-opcode check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_control_sequencer_pkg;

    // ALU opcodes accepted for reg-reg execution
    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_SHR = 5'd5;
    localparam logic [4:0] OP_SHL = 5'd6;
    localparam logic [4:0] OP_ROR = 5'd7;
    localparam logic [4:0] OP_ROL = 5'd8;
    localparam logic [4:0] OP_AND = 5'd9;
    localparam logic [4:0] OP_OR  = 5'd10;

    // IR field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 23;
    localparam int RB_MSB     = 22;
    localparam int RB_LSB     = 19;
    localparam int RC_MSB     = 18;
    localparam int RC_LSB     = 15;
    localparam int REG_SEL_W  = 4;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_sequencer_dec_4_16.sv
`default_nettype none
// ============================================================================
// Module   : dec_4_16
// Purpose  : 4-bit register field to one-hot register select, gated by an
//            enable so the sequencer can tie each decode to one state.
// Ports    : sel    in  4      register number from an IR field
//            en     in  1      decode enable (all outputs 0 when low)
//            onehot out WIDTH  one-hot register select
// Revision : 1.0 - initial release
// ============================================================================
module dec_4_16
    import alu_control_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [REG_SEL_W-1:0] sel,
    input  logic                 en,
    output logic [WIDTH-1:0]     onehot
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign onehot[i] = en && (sel == REG_SEL_W'(i));
    end

endmodule
`default_nettype wire

// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_sequencer
// Purpose  : Hardwired control FSM that fetches the instruction at PC through
//            a MAR/MDR memory handshake and then executes Ra <= Rb op Rc,
//            driving the datapath bus selects and register load strobes.
// Ports    : clk                    in  system clock
//            clr                    in  synchronous active-low reset
//            run                    in  start/continue, sampled in IDLE and T5
//            ir[31:0]               in  IR contents (opcode, Ra, Rb, Rc)
//            mem_ready              in  memory data valid this cycle
//            mem_read               out memory read request (address = MAR)
//            pc_out/zlo_out/mdr_out out bus source selects
//            mar_in/pc_enable/pc_increment/mdr_enable/mdr_read/ir_enable/
//            y_enable/zlo_enable    out register load strobes and MDR mux
//            op_code[4:0]           out ALU operation (T4 only)
//            r_enable/r_out         out one-hot GPR load / bus drive
//            busy                   out high outside IDLE and HALT
//            illegal/mem_err        out sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_sequencer
    import alu_control_sequencer_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                pc_out,
    output logic                zlo_out,
    output logic                mdr_out,
    output logic                mar_in,
    output logic                pc_enable,
    output logic                pc_increment,
    output logic                mdr_enable,
    output logic                mdr_read,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                zlo_enable,
    output logic [4:0]          op_code,
    output logic [NUM_REGS-1:0] r_enable,
    output logic [NUM_REGS-1:0] r_out,
    output logic                busy,
    output logic                illegal,
    output logic                mem_err
);

    localparam bit                 TIMEOUT_EN  = (MEM_TIMEOUT > 0);
    localparam int                 CNT_W       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [4:0]            w_opcode;
    logic                  w_op_legal;
    logic [NUM_REGS-1:0]   w_rb_sel;
    logic [NUM_REGS-1:0]   w_rc_sel;
    logic                  unused_ir_low;

    assign w_opcode      = ir[OPCODE_MSB:OPCODE_LSB];
    assign w_op_legal    = is_legal_op(w_opcode);
    assign unused_ir_low = ^ir[RC_LSB-1:0];

    // ------------------------------------------------------------------
    // State register, wait counter and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            illegal    <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (run) r_state <= S_T0;
                S_T0: begin
                    r_state    <= S_T1;
                    r_wait_cnt <= '0;
                end
                S_T1: begin
                    // A late mem_ready still wins on the final counted cycle
                    if (mem_ready) begin
                        r_state <= S_T2;
                    end else if (TIMEOUT_EN && (r_wait_cnt == TIMEOUT_VAL)) begin
                        mem_err <= 1'b1;
                        r_state <= S_HALT;
                    end else if (TIMEOUT_EN) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_op_legal) begin
                        r_state <= S_T4;
                    end else begin
                        illegal <= 1'b1;
                        r_state <= S_HALT;
                    end
                end
                S_T4:    r_state <= S_T5;
                S_T5:    r_state <= run ? S_T0 : S_IDLE;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register-field decoders, each tied to the single state that uses it
    // ------------------------------------------------------------------
    dec_4_16 #(.WIDTH(NUM_REGS)) u_dec_ra (
        .sel    (ir[RA_MSB:RA_LSB]),
        .en     (r_state == S_T5),
        .onehot (r_enable)
    );

    // Rb is only driven when the opcode is legal so an illegal decode
    // leaves the bus idle
    dec_4_16 #(.WIDTH(NUM_REGS)) u_dec_rb (
        .sel    (ir[RB_MSB:RB_LSB]),
        .en     ((r_state == S_T3) && w_op_legal),
        .onehot (w_rb_sel)
    );

    dec_4_16 #(.WIDTH(NUM_REGS)) u_dec_rc (
        .sel    (ir[RC_MSB:RC_LSB]),
        .en     (r_state == S_T4),
        .onehot (w_rc_sel)
    );

    assign r_out = w_rb_sel | w_rc_sel;

    // ------------------------------------------------------------------
    // Strobe decode of the state register
    // ------------------------------------------------------------------
    always_comb begin
        mem_read     = 1'b0;
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        mdr_out      = 1'b0;
        mar_in       = 1'b0;
        pc_enable    = 1'b0;
        pc_increment = 1'b0;
        mdr_enable   = 1'b0;
        mdr_read     = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        zlo_enable   = 1'b0;
        op_code      = 5'd0;
        busy         = (r_state != S_IDLE) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin
                pc_out       = 1'b1;
                mar_in       = 1'b1;
                pc_enable    = 1'b1;
                pc_increment = 1'b1;
            end
            S_T1: begin
                mem_read   = 1'b1;
                // MDR captures data_in in the same cycle the responder
                // presents it
                mdr_read   = mem_ready;
                mdr_enable = mem_ready;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: y_enable = w_op_legal;
            S_T4: begin
                op_code    = w_opcode;
                zlo_enable = 1'b1;
            end
            S_T5:    zlo_out = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_sequencer
// Purpose  : Directed self-checking bench for alu_control_sequencer: reset,
//            fetch/execute strobe traces, wait states, fetch timeout, illegal
//            opcode, back-to-back issue and reset in mid-instruction.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_sequencer;

    localparam int NUM_REGS = 16;

    // Strobe vector bit order:
    // mem_read pc_out zlo_out mdr_out mar_in pc_enable pc_increment
    // mdr_enable mdr_read ir_enable y_enable zlo_enable busy
    localparam logic [12:0] E_IDLE = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] E_T0   = 13'b0_1_0_0_1_1_1_0_0_0_0_0_1;
    localparam logic [12:0] E_T1W  = 13'b1_0_0_0_0_0_0_0_0_0_0_0_1;
    localparam logic [12:0] E_T1R  = 13'b1_0_0_0_0_0_0_1_1_0_0_0_1;
    localparam logic [12:0] E_T2   = 13'b0_0_0_1_0_0_0_0_0_1_0_0_1;
    localparam logic [12:0] E_T3   = 13'b0_0_0_0_0_0_0_0_0_0_1_0_1;
    localparam logic [12:0] E_T3I  = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;
    localparam logic [12:0] E_T4   = 13'b0_0_0_0_0_0_0_0_0_0_0_1_1;
    localparam logic [12:0] E_T5   = 13'b0_0_1_0_0_0_0_0_0_0_0_0_1;

    // op 7 (ror), Ra=4, Rb=3, Rc=0
    localparam logic [31:0] INSTR_ROR = 32'h3A18_0000;
    // op 4 (sub), Ra=2, Rb=9, Rc=15
    localparam logic [31:0] INSTR_SUB = {5'd4, 4'd2, 4'd9, 4'd15, 15'd0};
    // op 3 (add), Ra=5, Rb=6, Rc=7
    localparam logic [31:0] INSTR_ADD = {5'd3, 4'd5, 4'd6, 4'd7, 15'd0};
    // op 10 (or), Ra=Rb=Rc=1
    localparam logic [31:0] INSTR_OR  = {5'd10, 4'd1, 4'd1, 4'd1, 15'd0};
    // op 20 unsupported
    localparam logic [31:0] INSTR_ILL = {5'd20, 4'd1, 4'd2, 4'd3, 15'd0};

    logic                clk;
    logic                clr;
    logic                run;
    logic [31:0]         ir;
    logic                mem_ready;
    logic                mem_read;
    logic                pc_out;
    logic                zlo_out;
    logic                mdr_out;
    logic                mar_in;
    logic                pc_enable;
    logic                pc_increment;
    logic                mdr_enable;
    logic                mdr_read;
    logic                ir_enable;
    logic                y_enable;
    logic                zlo_enable;
    logic [4:0]          op_code;
    logic [NUM_REGS-1:0] r_enable;
    logic [NUM_REGS-1:0] r_out;
    logic                busy;
    logic                illegal;
    logic                mem_err;

    logic [12:0]         strobes;
    int                  tests;
    int                  fails;
    logic                watch_zlo;
    logic                zlo_seen;

    alu_control_sequencer #(
        .NUM_REGS    (NUM_REGS),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .run          (run),
        .ir           (ir),
        .mem_ready    (mem_ready),
        .mem_read     (mem_read),
        .pc_out       (pc_out),
        .zlo_out      (zlo_out),
        .mdr_out      (mdr_out),
        .mar_in       (mar_in),
        .pc_enable    (pc_enable),
        .pc_increment (pc_increment),
        .mdr_enable   (mdr_enable),
        .mdr_read     (mdr_read),
        .ir_enable    (ir_enable),
        .y_enable     (y_enable),
        .zlo_enable   (zlo_enable),
        .op_code      (op_code),
        .r_enable     (r_enable),
        .r_out        (r_out),
        .busy         (busy),
        .illegal      (illegal),
        .mem_err      (mem_err)
    );

    assign strobes = {mem_read, pc_out, zlo_out, mdr_out, mar_in, pc_enable,
                      pc_increment, mdr_enable, mdr_read, ir_enable, y_enable,
                      zlo_enable, busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (watch_zlo && zlo_enable) zlo_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [12:0] s, input logic [4:0] op,
                              input logic [15:0] ren, input logic [15:0] rout);
        check({tag, ".strobes"}, 32'(strobes), 32'(s));
        check({tag, ".op_code"}, 32'(op_code), 32'(op));
        check({tag, ".r_enable"}, 32'(r_enable), 32'(ren));
        check({tag, ".r_out"}, 32'(r_out), 32'(rout));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full instruction starting from IDLE or T5 with run=1.
    // waits = number of T1 cycles before mem_ready is raised.
    task automatic do_instr(input string tag, input int waits, input logic [31:0] instr,
                            input bit last);
        logic [15:0] one;
        logic [15:0] ra_oh;
        logic [15:0] rb_oh;
        logic [15:0] rc_oh;
        one   = 16'd1;
        ra_oh = one << instr[26:23];
        rb_oh = one << instr[22:19];
        rc_oh = one << instr[18:15];
        ir        = instr;
        mem_ready = 1'b0;
        tick();
        expect_cyc({tag, ".t0"}, E_T0, 5'd0, 16'd0, 16'd0);
        tick();
        for (int w = 0; w < waits; w++) begin
            expect_cyc({tag, ".t1wait"}, E_T1W, 5'd0, 16'd0, 16'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        expect_cyc({tag, ".t1ready"}, E_T1R, 5'd0, 16'd0, 16'd0);
        tick();
        mem_ready = 1'b0;
        expect_cyc({tag, ".t2"}, E_T2, 5'd0, 16'd0, 16'd0);
        tick();
        expect_cyc({tag, ".t3"}, E_T3, 5'd0, 16'd0, rb_oh);
        tick();
        expect_cyc({tag, ".t4"}, E_T4, instr[31:27], 16'd0, rc_oh);
        if (last) run = 1'b0;
        tick();
        expect_cyc({tag, ".t5"}, E_T5, 5'd0, ra_oh, 16'd0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        watch_zlo = 1'b0;
        zlo_seen  = 1'b0;
        clr       = 1'b0;
        run       = 1'b1;
        ir        = INSTR_ROR;
        mem_ready = 1'b1;

        // Reset with run held high
        tick();
        tick();
        expect_cyc("reset", E_IDLE, 5'd0, 16'd0, 16'd0);
        check("reset.illegal", 32'(illegal), 32'd0);
        check("reset.mem_err", 32'(mem_err), 32'd0);

        // Single ROR with zero wait, then back to IDLE
        clr = 1'b1;
        do_instr("ror", 0, INSTR_ROR, 1'b1);
        tick();
        expect_cyc("ror.idle", E_IDLE, 5'd0, 16'd0, 16'd0);

        // Three wait states: four T1 cycles
        run = 1'b1;
        do_instr("wait3", 3, INSTR_SUB, 1'b1);
        tick();
        expect_cyc("wait3.idle", E_IDLE, 5'd0, 16'd0, 16'd0);

        // Fetch timeout: 16 T1 cycles (count 0..15) then HALT
        run       = 1'b1;
        mem_ready = 1'b0;
        tick();
        expect_cyc("to.t0", E_T0, 5'd0, 16'd0, 16'd0);
        tick();
        expect_cyc("to.t1first", E_T1W, 5'd0, 16'd0, 16'd0);
        repeat (15) tick();
        expect_cyc("to.t1last", E_T1W, 5'd0, 16'd0, 16'd0);
        check("to.mem_err_pre", 32'(mem_err), 32'd0);
        tick();
        expect_cyc("to.halt", E_IDLE, 5'd0, 16'd0, 16'd0);
        check("to.mem_err", 32'(mem_err), 32'd1);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        expect_cyc("to.halt_run", E_IDLE, 5'd0, 16'd0, 16'd0);
        check("to.mem_err_sticky", 32'(mem_err), 32'd1);
        clr = 1'b0;
        tick();
        check("to.mem_err_clr", 32'(mem_err), 32'd0);
        run = 1'b0;
        clr = 1'b1;
        tick();
        expect_cyc("to.idle", E_IDLE, 5'd0, 16'd0, 16'd0);

        // Illegal opcode: no Y load, no bus drive, then HALT
        ir        = INSTR_ILL;
        run       = 1'b1;
        mem_ready = 1'b1;
        tick();
        expect_cyc("ill.t0", E_T0, 5'd0, 16'd0, 16'd0);
        run = 1'b0;
        tick();
        expect_cyc("ill.t1", E_T1R, 5'd0, 16'd0, 16'd0);
        tick();
        tick();
        expect_cyc("ill.t3", E_T3I, 5'd0, 16'd0, 16'd0);
        check("ill.flag_pre", 32'(illegal), 32'd0);
        tick();
        expect_cyc("ill.halt", E_IDLE, 5'd0, 16'd0, 16'd0);
        check("ill.flag", 32'(illegal), 32'd1);
        run = 1'b1;
        tick();
        tick();
        expect_cyc("ill.halt_run", E_IDLE, 5'd0, 16'd0, 16'd0);
        check("ill.flag_sticky", 32'(illegal), 32'd1);
        clr = 1'b0;
        tick();
        check("ill.flag_clr", 32'(illegal), 32'd0);
        run = 1'b0;
        clr = 1'b1;
        tick();

        // Back-to-back issue: each T5 followed directly by T0
        run = 1'b1;
        do_instr("b2b0", 0, INSTR_ADD, 1'b0);
        do_instr("b2b1", 1, INSTR_OR, 1'b0);
        do_instr("b2b2", 0, INSTR_ROR, 1'b1);
        tick();
        expect_cyc("b2b.idle", E_IDLE, 5'd0, 16'd0, 16'd0);

        // Reset during T4
        ir        = INSTR_ADD;
        run       = 1'b1;
        mem_ready = 1'b1;
        repeat (5) tick();
        expect_cyc("mid.t4", E_T4, 5'd3, 16'd0, 16'd1 << 7);
        clr = 1'b0;
        tick();
        watch_zlo = 1'b1;
        expect_cyc("mid.reset", E_IDLE, 5'd0, 16'd0, 16'd0);
        tick();
        run = 1'b0;
        clr = 1'b1;
        repeat (3) tick();
        expect_cyc("mid.idle", E_IDLE, 5'd0, 16'd0, 16'd0);
        check("mid.no_zlo_enable", 32'(zlo_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
